// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer
//   Turns raw PS/2 set-2 scan bytes into LOGO command words. Break and extended
//   prefixes are stripped, make codes are mapped to ASCII and packed right-justified
//   (up to 4 chars) into a 32-bit line buffer with backspace editing. Enter commits
//   the line into a small first-word fall-through FIFO drained via valid/ready.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   key_valid_i/code_i  one-cycle strobe with a received PS/2 byte
//   cmd_valid_o/data_o  FIFO head (data is 0 when empty); cmd_ready_i pops it
//   echo_valid_o/char_o one-cycle LCD echo (ASCII, 8'h08 backspace, 8'h0D enter)
//   edit_word_o/count_o line being assembled and its character count
//   fifo_count_o        committed words queued
//   drop_o              one-cycle strobe: key rejected (line full or FIFO full)
module ps2_command_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  BREAK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE   = 8'hE0,
    parameter logic [7:0]  ENTER_CODE = 8'h5A,
    parameter logic [7:0]  BKSP_CODE  = 8'h66
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_valid_i,
    input  logic [7:0]                  key_code_i,
    output logic                        cmd_valid_o,
    output logic [31:0]                 cmd_data_o,
    input  logic                        cmd_ready_i,
    output logic                        echo_valid_o,
    output logic [7:0]                  echo_char_o,
    output logic [31:0]                 edit_word_o,
    output logic [2:0]                  edit_count_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        drop_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StBrk, StExt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     word_q, word_d;
    logic [2:0]      count_q, count_d;
    logic            echo_valid_q, echo_valid_d;
    logic [7:0]      echo_char_q, echo_char_d;
    logic            drop_q, drop_d;

    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] fifo_count_q, fifo_count_d;

    logic            make;
    logic            is_print;
    logic [7:0]      ascii;
    logic            push, pop, fifo_full;

    // Set-2 scan code to ASCII for A-Z and 0-9; anything else is unmapped.
    always_comb begin
        is_print = 1'b1;
        ascii    = 8'h00;
        case (key_code_i)
            8'h1C: ascii = 8'h41; 8'h32: ascii = 8'h42; 8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44; 8'h24: ascii = 8'h45; 8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47; 8'h33: ascii = 8'h48; 8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A; 8'h42: ascii = 8'h4B; 8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D; 8'h31: ascii = 8'h4E; 8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50; 8'h15: ascii = 8'h51; 8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53; 8'h2C: ascii = 8'h54; 8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56; 8'h1D: ascii = 8'h57; 8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59; 8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            default: is_print = 1'b0;
        endcase
    end

    assign fifo_full   = (fifo_count_q == CntW'(FIFO_DEPTH));
    assign cmd_valid_o = (fifo_count_q != '0);
    assign pop         = cmd_valid_o && cmd_ready_i;
    assign cmd_data_o  = cmd_valid_o ? mem_q[rd_ptr_q] : 32'h0;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        count_d      = count_q;
        echo_valid_d = 1'b0;
        echo_char_d  = echo_char_q;
        drop_d       = 1'b0;
        make         = 1'b0;
        push         = 1'b0;

        if (key_valid_i) begin
            unique case (state_q)
                StIdle: begin
                    if (key_code_i == BREAK_CODE)    state_d = StBrk;
                    else if (key_code_i == EXT_CODE) state_d = StExt;
                    else                             make    = 1'b1;
                end
                StBrk: state_d = StIdle;
                StExt: state_d = (key_code_i == BREAK_CODE) ? StBrk : StIdle;
                default: state_d = StIdle;
            endcase
        end

        if (make) begin
            if (key_code_i == ENTER_CODE) begin
                if (count_q != 3'd0) begin
                    // A same-cycle pop frees a slot even when the FIFO is full.
                    if (!fifo_full || pop) begin
                        push         = 1'b1;
                        word_d       = 32'h0;
                        count_d      = 3'd0;
                        echo_valid_d = 1'b1;
                        echo_char_d  = 8'h0D;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end else if (key_code_i == BKSP_CODE) begin
                if (count_q != 3'd0) begin
                    word_d       = word_q >> 8;
                    count_d      = count_q - 3'd1;
                    echo_valid_d = 1'b1;
                    echo_char_d  = 8'h08;
                end
            end else if (is_print) begin
                if (count_q < 3'd4) begin
                    word_d       = {word_q[23:0], ascii};
                    count_d      = count_q + 3'd1;
                    echo_valid_d = 1'b1;
                    echo_char_d  = ascii;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CntW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CntW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            word_q       <= 32'h0;
            count_q      <= 3'd0;
            echo_valid_q <= 1'b0;
            echo_char_q  <= 8'h00;
            drop_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            count_q      <= count_d;
            echo_valid_q <= echo_valid_d;
            echo_char_q  <= echo_char_d;
            drop_q       <= drop_d;
            fifo_count_q <= fifo_count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= word_q;
    end

    assign echo_valid_o = echo_valid_q;
    assign echo_char_o  = echo_char_q;
    assign edit_word_o  = word_q;
    assign edit_count_o = count_q;
    assign fifo_count_o = fifo_count_q;
    assign drop_o       = drop_q;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
module tb_ps2_command_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        echo_valid;
    logic [7:0]  echo_char;
    logic [31:0] edit_word;
    logic [2:0]  edit_count;
    logic [2:0]  fifo_count;
    logic        drop;

    int checks = 0;
    int errors = 0;
    int echoes_seen = 0;

    logic [7:0]  exp_echo[$];
    logic [31:0] exp_cmd[$];

    ps2_command_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .cmd_valid_o (cmd_valid),
        .cmd_data_o  (cmd_data),
        .cmd_ready_i (cmd_ready),
        .echo_valid_o(echo_valid),
        .echo_char_o (echo_char),
        .edit_word_o (edit_word),
        .edit_count_o(edit_count),
        .fifo_count_o(fifo_count),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: echoes and popped words are checked against the scoreboard.
    always @(negedge clk) begin
        if (echo_valid === 1'b1) begin
            echoes_seen++;
            checks++;
            if (exp_echo.size() == 0) begin
                errors++;
                $display("FAIL echo_unexpected got %h want none", echo_char);
            end else begin
                logic [7:0] e;
                e = exp_echo.pop_front();
                if (echo_char !== e) begin
                    errors++;
                    $display("FAIL echo_char got %h want %h", echo_char, e);
                end
            end
            if (drop === 1'b1) begin
                errors++;
                $display("FAIL echo_and_drop got both want exclusive");
            end
        end
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected got %h want none", cmd_data);
            end else begin
                logic [31:0] w;
                w = exp_cmd.pop_front();
                if (cmd_data !== w) begin
                    errors++;
                    $display("FAIL cmd_order got %h want %h", cmd_data, w);
                end
            end
        end
    end

    // Drives one byte for one cycle; returns 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] code);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic type_key(input logic [7:0] code, input logic [7:0] asc);
        exp_echo.push_back(asc);
        send(code);
        send(8'hF0);
        send(code);
    endtask

    task automatic commit(input logic [31:0] w);
        exp_cmd.push_back(w);
        exp_echo.push_back(8'h0D);
        send(8'h5A);
        send(8'hF0);
        send(8'h5A);
    endtask

    task automatic test_reset;
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (edit_word !== 32'h0 || edit_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_edit got %h/%0d want 0/0", edit_word, edit_count);
        end
        checks++;
        if (fifo_count !== 3'd0 || cmd_valid !== 1'b0 || cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_fifo got %0d/%b/%h want 0/0/0", fifo_count, cmd_valid, cmd_data);
        end
        checks++;
        if (echo_valid !== 1'b0 || echo_char !== 8'h00 || drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b/%h/%b want 0/00/0", echo_valid, echo_char, drop);
        end
        reset = 1'b0;
    endtask

    task automatic test_typing;
        int e0;
        e0 = echoes_seen;
        type_key(8'h1C, 8'h41);
        type_key(8'h32, 8'h42);
        @(posedge clk); #1;
        checks++;
        if (edit_word !== 32'h00004142 || edit_count !== 3'd2) begin
            errors++;
            $display("FAIL typing_word got %h/%0d want 00004142/2", edit_word, edit_count);
        end
        checks++;
        if (echoes_seen - e0 != 2 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL typing_echoes got %0d/%b want 2/0", echoes_seen - e0, cmd_valid);
        end
        exp_echo.push_back(8'h08); send(8'h66);
        exp_echo.push_back(8'h08); send(8'h66);
        checks++;
        if (edit_count !== 3'd0 || edit_word !== 32'h0) begin
            errors++;
            $display("FAIL typing_clear got %h/%0d want 0/0", edit_word, edit_count);
        end
    endtask

    task automatic test_commit;
        type_key(8'h2B, 8'h46);
        type_key(8'h23, 8'h44);
        type_key(8'h16, 8'h31);
        type_key(8'h45, 8'h30);
        exp_cmd.push_back(32'h46443130);
        exp_echo.push_back(8'h0D);
        send(8'h5A);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 32'h46443130 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL commit_head got %b/%h/%0d want 1/46443130/1",
                     cmd_valid, cmd_data, fifo_count);
        end
        checks++;
        if (edit_count !== 3'd0 || edit_word !== 32'h0) begin
            errors++;
            $display("FAIL commit_clear got %h/%0d want 0/0", edit_word, edit_count);
        end
        send(8'hF0); send(8'h5A);
        @(posedge clk); #1; cmd_ready = 1'b1;
        @(posedge clk); #1; cmd_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || cmd_valid !== 1'b0 || cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL commit_drain got %0d/%b/%h want 0/0/0", fifo_count, cmd_valid, cmd_data);
        end
    endtask

    task automatic test_line_full;
        type_key(8'h1C, 8'h41);
        type_key(8'h32, 8'h42);
        type_key(8'h21, 8'h43);
        type_key(8'h23, 8'h44);
        send(8'h24);
        checks++;
        if (drop !== 1'b1 || echo_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drop got %b/%b want 1/0", drop, echo_valid);
        end
        checks++;
        if (edit_word !== 32'h41424344 || edit_count !== 3'd4) begin
            errors++;
            $display("FAIL full_word got %h/%0d want 41424344/4", edit_word, edit_count);
        end
        send(8'hF0); send(8'h24);
        exp_echo.push_back(8'h08);
        send(8'h66);
        checks++;
        if (edit_word !== 32'h00414243 || edit_count !== 3'd3 || echo_char !== 8'h08) begin
            errors++;
            $display("FAIL bksp_word got %h/%0d/%h want 00414243/3/08",
                     edit_word, edit_count, echo_char);
        end
        for (int i = 0; i < 3; i++) begin
            exp_echo.push_back(8'h08);
            send(8'h66);
        end
        send(8'h66);
        checks++;
        if (echo_valid !== 1'b0 || drop !== 1'b0 || edit_count !== 3'd0 || edit_word !== 32'h0) begin
            errors++;
            $display("FAIL bksp_empty got %b/%b/%0d/%h want 0/0/0/0",
                     echo_valid, drop, edit_count, edit_word);
        end
    endtask

    task automatic test_fifo_full;
        int budget;
        type_key(8'h1C, 8'h41); commit(32'h00000041);
        type_key(8'h32, 8'h42); commit(32'h00000042);
        type_key(8'h21, 8'h43); commit(32'h00000043);
        type_key(8'h23, 8'h44); commit(32'h00000044);
        type_key(8'h24, 8'h45);
        send(8'h5A);
        checks++;
        if (drop !== 1'b1 || echo_valid !== 1'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL fifo_full_drop got %b/%b/%0d want 1/0/4", drop, echo_valid, fifo_count);
        end
        checks++;
        if (edit_word !== 32'h00000045 || edit_count !== 3'd1) begin
            errors++;
            $display("FAIL fifo_full_keep got %h/%0d want 00000045/1", edit_word, edit_count);
        end
        // Retry Enter with a simultaneous pop: accepted, count unchanged.
        exp_cmd.push_back(32'h00000045);
        exp_echo.push_back(8'h0D);
        @(posedge clk); #1;
        key_valid = 1'b1; key_code = 8'h5A; cmd_ready = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; cmd_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || edit_count !== 3'd0 || drop !== 1'b0 || cmd_data !== 32'h42) begin
            errors++;
            $display("FAIL fifo_push_pop got %0d/%0d/%b/%h want 4/0/0/00000042",
                     fifo_count, edit_count, drop, cmd_data);
        end
        cmd_ready = 1'b1;
        budget = 0;
        while (fifo_count !== 3'd0 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        cmd_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL fifo_drain got %0d/%0d want 0/0", fifo_count, exp_cmd.size());
        end
    endtask

    task automatic test_extended;
        logic [7:0] seq [9];
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h1C, 8'hE0, 8'h66};
        for (int i = 0; i < 9; i++) begin
            send(seq[i]);
            checks++;
            if (echo_valid !== 1'b0 || drop !== 1'b0 || edit_count !== 3'd0) begin
                errors++;
                $display("FAIL ext_ignored byte %0d got %b/%b/%0d want 0/0/0",
                         i, echo_valid, drop, edit_count);
            end
        end
        send(8'h5A);
        checks++;
        if (fifo_count !== 3'd0 || echo_valid !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL empty_enter got %0d/%b/%b want 0/0/0", fifo_count, echo_valid, drop);
        end
    endtask

    task automatic test_reset_mid;
        type_key(8'h2C, 8'h54); commit(32'h00000054);
        type_key(8'h2D, 8'h52); commit(32'h00000052);
        type_key(8'h1C, 8'h41);
        type_key(8'h32, 8'h42);
        type_key(8'h21, 8'h43);
        send(8'hF0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        exp_cmd.delete();
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_fifo got %b/%0d/%h want 0/0/0", cmd_valid, fifo_count, cmd_data);
        end
        checks++;
        if (edit_word !== 32'h0 || edit_count !== 3'd0) begin
            errors++;
            $display("FAIL midreset_edit got %h/%0d want 0/0", edit_word, edit_count);
        end
        exp_echo.push_back(8'h41);
        send(8'h1C);
        checks++;
        if (edit_word !== 32'h00000041 || edit_count !== 3'd1 || echo_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_idle got %h/%0d/%b want 00000041/1/1",
                     edit_word, edit_count, echo_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (exp_echo.size() != 0) begin
            errors++;
            $display("FAIL echo_leftover got %0d want 0", exp_echo.size());
        end
    endtask

    initial begin
        test_reset();
        test_typing();
        test_commit();
        test_line_full();
        test_fifo_full();
        test_extended();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
- Converts the raw PS/2 scan-code byte stream into complete LOGO command words for the processor.
- Strips make/break and extended prefixes, maps keys to ASCII, and packs up to 4 characters right-justified into a 32-bit word.
- Supports backspace editing; commits the word on Enter.
- Queues committed words in a small FIFO drained by the processor through a valid/ready handshake, and echoes accepted keys to the LCD path.

Parameters:
- FIFO_DEPTH, 4, number of committed command words buffered (power of 2, >= 2).
- BREAK_CODE, 8'hF0, PS/2 break prefix.
- EXT_CODE, 8'hE0, PS/2 extended prefix.
- ENTER_CODE, 8'h5A, scan code that commits the current word.
- BKSP_CODE, 8'h66, scan code that deletes the last character.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code holds a newly received PS/2 byte
- key_code  in  8  raw PS/2 byte
- cmd_valid  out  1  FIFO non-empty; cmd_data is valid
- cmd_data  out  32  FIFO head word (first-word fall-through)
- cmd_ready  in  1  processor accepts cmd_data this cycle
- echo_valid  out  1  one-cycle strobe for LCD echo
- echo_char  out  8  ASCII echo character, or 8'h08 (backspace) or 8'h0D (enter)
- edit_word  out  32  word currently being assembled
- edit_count  out  3  characters in edit_word (0..4)
- fifo_count  out  log2(FIFO_DEPTH)+1  committed words queued
- drop  out  1  one-cycle strobe: a key was rejected (line full, or FIFO full on Enter)

Behaviour:
- Reset (synchronous, clk edge while reset=1):
  - Prefix FSM goes to IDLE.
  - edit_word=0, edit_count=0, FIFO empty (fifo_count=0, cmd_valid=0, cmd_data=0).
  - echo_valid=0, echo_char=0, drop=0.
  - Reset mid-entry discards the partial word and all queued words.
- Prefix FSM (advances only on key_valid):
  - IDLE: BREAK_CODE -> BRK; EXT_CODE -> EXT; any other byte is a make code and is processed, staying in IDLE.
  - BRK: next byte discarded (key release) -> IDLE.
  - EXT: BREAK_CODE -> BRK; any other byte discarded -> IDLE. Extended keys are not supported.
- Make-code processing (all results registered; visible at cycle N+1 for key_valid at N):
  - Printable: internal scan-to-ASCII table covers A-Z (8'h41-8'h5A) and 0-9 (8'h30-8'h39), using standard PS/2 set-2 codes. Unmapped codes are ignored silently: no echo, no drop.
  - Printable with edit_count<4: edit_word <= {edit_word[23:0], ascii}; edit_count+1; echo_valid=1, echo_char=ascii. The first character ends in the most significant occupied byte.
  - Printable with edit_count==4: word unchanged; drop=1; no echo.
  - BKSP with edit_count>0: edit_word <= edit_word>>8; edit_count-1; echo 8'h08. BKSP with edit_count==0: ignored.
  - ENTER with edit_count==0: ignored (empty commands are never queued).
  - ENTER with edit_count>0 and FIFO has space: push edit_word; clear edit_word and edit_count; echo 8'h0D.
  - ENTER with FIFO full and no pop in the same cycle: drop=1; edit word retained so the user can retry.
- FIFO:
  - cmd_valid = (fifo_count!=0); cmd_data is the head entry combinationally, and 0 when empty.
  - Pop when cmd_valid && cmd_ready. cmd_ready while empty has no effect.
  - Simultaneous push and pop: both occur and fifo_count is unchanged. When full, a same-cycle pop makes room, so the push is accepted.
  - Read and write pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end, because the rules above prevent overflow and underflow.
- echo_valid and drop are single-cycle pulses and are never asserted in the same cycle.

Test Plan:
- Reset, then key bytes 1C,F0,1C,32,F0,32 (A,B with releases) -> edit_word=32'h00004142, edit_count=2, exactly two echo pulses (41, 42), cmd_valid=0.
- Type F,D,1,0 (2B,23,16,45, each followed by F0+code), then Enter 5A -> cmd_valid=1 at cycle N+1 with cmd_data=32'h46443130; echo 0D; edit_count=0.
- Type five characters (A,B,C,D,E) -> fifth produces drop pulse and no echo; edit_word=32'h41424344. Then BKSP 66 -> 32'h00414243, echo 08. BKSP with count 0 -> no response.
- Hold cmd_ready=0, commit 4 words, then a 5th Enter -> drop=1, fifo_count=4, edit word kept. Repeat Enter with cmd_ready=1 in the same cycle -> accepted, fifo_count stays 4, heads pop in FIFO order.
- E0,75 then E0,F0,75 (extended key press and release) -> no state change, no echo, no drop. Enter with an empty line -> no push.
- Assert reset after 2 queued words and 3 typed characters -> next cycle cmd_valid=0, fifo_count=0, edit_word=0, FSM IDLE. A following F0-free make code is processed normally.
